menu_screen_countdown: RTL and testbench

//  Generalised lobby/menu renderer with its own start countdown. Draws the

---
 rtl/menu_screen_countdown_pkg.sv | 54 +++++
 rtl/menu_screen_countdown_if.sv | 39 +++
 rtl/menu_layout_decode.sv | 43 ++++
 rtl/menu_screen_countdown.sv | 162 ++++++++++++++++
 tb/tb_menu_screen_countdown.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/menu_screen_countdown_pkg.sv
// Shared types and constants for the lobby/menu countdown screen:
// player colour table, fixed intensities, FSM states and layout helpers.
package menu_pkg;

  localparam logic [7:0]  LIT   = 8'd5;
  localparam logic [23:0] WHITE = {LIT, LIT, LIT};   // {g, r, b}
  localparam logic [23:0] BLACK = 24'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } menu_state_e;

  // Player colours as {g, r, b} at the lit level: R, G, B, Y repeating.
  function automatic logic [23:0] player_colour(input int p);
    logic [23:0] c;
    case (p % 4)
      0:       c = {8'd0, LIT, 8'd0};
      1:       c = {LIT, 8'd0, 8'd0};
      2:       c = {8'd0, 8'd0, LIT};
      default: c = {LIT, LIT, 8'd0};
    endcase
    return c;
  endfunction

  // Same hue, every non-zero channel replaced by the given level.
  function automatic logic [23:0] dim_colour(input logic [23:0] c, input logic [7:0] level);
    logic [23:0] d;
    for (int i = 0; i < 3; i++)
      d[i*8 +: 8] = (c[i*8 +: 8] != 8'd0) ? level : 8'd0;
    return d;
  endfunction

  // Segment length of a row: rows shrink by one toward the apex.
  function automatic int seg_len(input int num_rows, input int row);
    return num_rows + 1 - row;
  endfunction

  // First LED index of a row.
  function automatic int row_start(input int num_players, input int num_rows, input int row);
    int acc;
    acc = 0;
    for (int j = 0; j < row; j++)
      acc += num_players * seg_len(num_rows, j);
    return acc;
  endfunction

  // All segments plus the single apex LED.
  function automatic int num_leds(input int num_players, input int num_rows);
    return row_start(num_players, num_rows, num_rows) + 1;
  endfunction

endpackage

// File: rtl/menu_screen_countdown_if.sv
// Pixel-chain and control bundle for the menu countdown screen.
interface menu_screen_countdown_if
  import menu_pkg::*;
#(
  parameter int NUM_PLAYERS = 4,
  parameter int NUM_ROWS    = 6
);
  localparam int LW = $clog2(num_leds(NUM_PLAYERS, NUM_ROWS));
  localparam int CW = $clog2(NUM_ROWS + 2);

  logic                   enable;
  logic [7:0]             i_red_intensity;
  logic [7:0]             i_green_intensity;
  logic [7:0]             i_blue_intensity;
  logic                   led_valid;
  logic [LW-1:0]          led_number;
  logic [NUM_PLAYERS-1:0] ready_to_play;
  logic [7:0]             o_red_intensity;
  logic [7:0]             o_green_intensity;
  logic [7:0]             o_blue_intensity;
  logic                   o_valid;
  logic [CW-1:0]          countdown;
  logic                   o_go;

  modport master (
    output enable, i_red_intensity, i_green_intensity, i_blue_intensity,
           led_valid, led_number, ready_to_play,
    input  o_red_intensity, o_green_intensity, o_blue_intensity,
           o_valid, countdown, o_go
  );

  modport slave (
    input  enable, i_red_intensity, i_green_intensity, i_blue_intensity,
           led_valid, led_number, ready_to_play,
    output o_red_intensity, o_green_intensity, o_blue_intensity,
           o_valid, countdown, o_go
  );

endinterface

// File: rtl/menu_layout_decode.sv
// Maps a flat LED index onto the player-segment triangle:
// row, segment (player) and offset within the segment, plus apex/range flags.
module menu_layout_decode
  import menu_pkg::*;
#(
  parameter int NUM_PLAYERS = 4,
  parameter int NUM_ROWS    = 6,
  localparam int NUM_LEDS   = num_leds(NUM_PLAYERS, NUM_ROWS),
  localparam int LW         = $clog2(NUM_LEDS),
  localparam int RW         = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int PW         = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
  localparam int KW         = $clog2(NUM_ROWS + 1)
) (
  input  logic [LW-1:0] i_led_number,
  output logic [RW-1:0] o_row,
  output logic [PW-1:0] o_seg,
  output logic [KW-1:0] o_offset,
  output logic          o_is_apex,
  output logic          o_in_range
);

  // Range-compare against every constant segment window; windows are disjoint.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
    o_row      = '0;
    o_seg      = '0;
    o_offset   = '0;
    o_in_range = int'(i_led_number) < NUM_LEDS;
    o_is_apex  = int'(i_led_number) == NUM_LEDS - 1;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (int'(i_led_number) >= row_start(NUM_PLAYERS, NUM_ROWS, r) + p * seg_len(NUM_ROWS, r) &&
            int'(i_led_number) <  row_start(NUM_PLAYERS, NUM_ROWS, r) + (p + 1) * seg_len(NUM_ROWS, r)) begin
          o_row    = RW'(r);
          o_seg    = PW'(p);
          o_offset = KW'(int'(i_led_number) - row_start(NUM_PLAYERS, NUM_ROWS, r)
                         - p * seg_len(NUM_ROWS, r));
        end
      end
    end
  end

endmodule

// File: rtl/menu_screen_countdown.sv
// Lobby/menu renderer with built-in ready -> countdown -> go sequencing.
// Overrides upstream pixels while enabled, registered pass-through otherwise.
module menu_screen_countdown
  import menu_pkg::*;
#(
  parameter int         NUM_PLAYERS    = 4,
  parameter int         NUM_ROWS       = 6,
  parameter int         MIN_PLAYERS    = 2,
  parameter int         TICKS_PER_STEP = 25000000,
  parameter int         BLINK_TICKS    = 12500000,
  parameter logic [7:0] DIM            = 8'd1
) (
  input logic                    clk,
  input logic                    rst_n,
  menu_screen_countdown_if.slave bus
);

  localparam int CW = $clog2(NUM_ROWS + 2);
  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int KW = $clog2(NUM_ROWS + 1);
  localparam int SW = $clog2(TICKS_PER_STEP);
  localparam int BW = $clog2(BLINK_TICKS);
  localparam logic [CW-1:0] CD_FULL = CW'(NUM_ROWS + 1);

  menu_state_e   r_state, w_state_nxt;
  logic [CW-1:0] r_countdown, w_countdown_nxt;
  logic [SW-1:0] r_step_cnt, w_step_cnt_nxt;
  logic          r_go, w_go_nxt;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_phase;
  logic [23:0]   r_pixel;         // {g, r, b}
  logic          r_valid;

  logic          w_enough;
  logic [RW-1:0] w_row;
  logic [PW-1:0] w_seg;
  logic [KW-1:0] w_offset;
  logic          w_is_apex;
  logic          w_in_range;
  logic [23:0]   w_pixel;

  assign w_enough = $countones(bus.ready_to_play) >= MIN_PLAYERS;

  menu_layout_decode #(
    .NUM_PLAYERS(NUM_PLAYERS),
    .NUM_ROWS   (NUM_ROWS)
  ) u_decode (
    .i_led_number(bus.led_number),
    .o_row       (w_row),
    .o_seg       (w_seg),
    .o_offset    (w_offset),
    .o_is_apex   (w_is_apex),
    .o_in_range  (w_in_range)
  );

  // Next-state: disable forces IDLE, abort beats a same-cycle decrement.
  always_comb begin
    w_state_nxt     = r_state;
    w_countdown_nxt = r_countdown;
    w_step_cnt_nxt  = r_step_cnt;
    w_go_nxt        = 1'b0;
    if (!bus.enable) begin
      w_state_nxt     = IDLE;
      w_countdown_nxt = CD_FULL;
      w_step_cnt_nxt  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_enough) begin
            w_state_nxt    = COUNT;
            w_step_cnt_nxt = '0;
          end
        end
        COUNT: begin
          if (!w_enough) begin
            w_state_nxt     = IDLE;
            w_countdown_nxt = CD_FULL;
            w_step_cnt_nxt  = '0;
          end else if (r_step_cnt == SW'(TICKS_PER_STEP - 1)) begin
            w_step_cnt_nxt  = '0;
            w_countdown_nxt = r_countdown - CW'(1);
            if (r_countdown == CW'(1)) begin
              w_state_nxt = DONE;
              w_go_nxt    = 1'b1;
            end
          end else begin
            w_step_cnt_nxt = r_step_cnt + SW'(1);
          end
        end
        DONE:    ;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // FSM, countdown, step prescaler and go pulse registers.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      r_state     <= IDLE;
      r_countdown <= CD_FULL;
      r_step_cnt  <= '0;
      r_go        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_countdown <= w_countdown_nxt;
      r_step_cnt  <= w_step_cnt_nxt;
      r_go        <= w_go_nxt;
    end
  end

  // Free-running blink half-period counter, parked at zero while disabled.
  always_ff @(posedge clk) begin
    if (!rst_n || !bus.enable) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == BW'(BLINK_TICKS - 1)) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + BW'(1);
    end
  end

  // Pixel priority: apex, countdown marker, ready bar, blinking hint, black.
  always_comb begin
    w_pixel = BLACK;
    if (w_is_apex) begin
      if (r_countdown != '0) w_pixel = WHITE;
    end else if (w_in_range) begin
      if (w_offset == '0) begin
        if (int'(r_countdown) >= NUM_ROWS + 1 - int'(w_row)) w_pixel = WHITE;
      end else if (bus.ready_to_play[w_seg]) begin
        w_pixel = player_colour(int'(w_seg));
      end else if (r_state == IDLE && r_blink_phase) begin
        w_pixel = dim_colour(player_colour(int'(w_seg)), DIM);
      end
    end
  end

  // Output register: one cycle latency, holds pixel when no LED is presented.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pixel <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= bus.led_valid;
      if (bus.led_valid)
        r_pixel <= bus.enable ? w_pixel
                              : {bus.i_green_intensity, bus.i_red_intensity, bus.i_blue_intensity};
    end
  end

  assign bus.o_green_intensity = r_pixel[23:16];
  assign bus.o_red_intensity   = r_pixel[15:8];
  assign bus.o_blue_intensity  = r_pixel[7:0];
  assign bus.o_valid           = r_valid;
  assign bus.countdown         = r_countdown;
  assign bus.o_go              = r_go;

endmodule

// File: tb/tb_menu_screen_countdown.sv
// Scoreboard bench for menu_screen_countdown: a behavioural model predicts each
// registered pixel, countdown and go value; a monitor compares on o_valid.
module tb_menu_screen_countdown;

  localparam int NP       = 4;
  localparam int NR       = 6;
  localparam int NUM_LEDS = 109;
  localparam int TPS      = 4;
  localparam int BT       = 3;
  localparam int CD_FULL  = NR + 1;
  localparam logic [7:0] DIMV = 8'd1;
  localparam int M_IDLE = 0, M_COUNT = 1, M_DONE = 2;

  typedef struct {
    logic [23:0] pix;
    int          cd;
    bit          go;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  menu_screen_countdown_if #(.NUM_PLAYERS(NP), .NUM_ROWS(NR)) bus ();

  menu_screen_countdown #(
    .NUM_PLAYERS   (NP),
    .NUM_ROWS      (NR),
    .MIN_PLAYERS   (2),
    .TICKS_PER_STEP(TPS),
    .BLINK_TICKS   (BT),
    .DIM           (DIMV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_go_exp = 0;
  int n_go_seen = 0;
  exp_t exp_q[$];

  // {g, r, b} per player: red, green, blue, yellow.
  logic [23:0] lit_col [4] = '{24'h000500, 24'h050000, 24'h000005, 24'h050500};
  logic [23:0] dim_col [4] = '{24'h000100, 24'h010000, 24'h000001, 24'h010100};

  int tab_row [NUM_LEDS];
  int tab_seg [NUM_LEDS];
  int tab_k   [NUM_LEDS];

  // Model: mode, edges spent counting, enabled edges (for blink), go flag, held pixel.
  int          m_mode;
  int          m_run;
  int          m_en;
  bit          m_go;
  logic [23:0] m_pix;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int model_countdown();
    if (m_mode == M_IDLE)  return CD_FULL;
    if (m_mode == M_COUNT) return CD_FULL - m_run / TPS;
    return 0;
  endfunction

  function automatic logic [23:0] render(input int led, input int cd, input int mode,
                                         input bit ph, input logic [3:0] rdy);
    int r, p, k;
    if (led >= NUM_LEDS) return 24'h0;
    if (led == NUM_LEDS - 1) return (cd >= 1) ? 24'h050505 : 24'h0;
    r = tab_row[led];
    p = tab_seg[led];
    k = tab_k[led];
    if (k == 0) return (cd >= NR + 1 - r) ? 24'h050505 : 24'h0;
    if (rdy[p]) return lit_col[p];
    if (mode == M_IDLE && ph) return dim_col[p];
    return 24'h0;
  endfunction

  // One clock: predict from pre-edge model state and current inputs, then advance.
  task automatic step();
    int   cd_pre;
    int   mode_pre;
    bit   ph_pre;
    bit   enough;
    exp_t e;
    cd_pre   = model_countdown();
    mode_pre = m_mode;
    ph_pre   = ((m_en / BT) % 2) == 1;
    if (!rst_n) begin
      m_mode = M_IDLE; m_run = 0; m_en = 0; m_go = 0; m_pix = '0;
    end else begin
      if (bus.led_valid)
        m_pix = bus.enable ? render(int'(bus.led_number), cd_pre, mode_pre, ph_pre, bus.ready_to_play)
                           : {bus.i_green_intensity, bus.i_red_intensity, bus.i_blue_intensity};
      m_go = 0;
      if (!bus.enable) begin
        m_mode = M_IDLE; m_run = 0; m_en = 0;
      end else begin
        enough = $countones(bus.ready_to_play) >= 2;
        m_en++;
        if (m_mode == M_IDLE) begin
          if (enough) begin m_mode = M_COUNT; m_run = 0; end
        end else if (m_mode == M_COUNT) begin
          if (!enough) m_mode = M_IDLE;
          else begin
            m_run++;
            if (m_run == CD_FULL * TPS) begin m_mode = M_DONE; m_go = 1; end
          end
        end
      end
      if (bus.led_valid) begin
        e.pix = m_pix;
        e.cd  = model_countdown();
        e.go  = m_go;
        exp_q.push_back(e);
        if (m_go) n_go_exp++;
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      #1;
      check("rst_valid", 32'(bus.o_valid), 32'd0);
      check("rst_pixel", {8'd0, bus.o_green_intensity, bus.o_red_intensity, bus.o_blue_intensity}, 32'd0);
      check("rst_countdown", 32'(bus.countdown), CD_FULL);
      check("rst_go", 32'(bus.o_go), 32'd0);
    end
    @(negedge clk);
  endtask

  function automatic int pick_led();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return NUM_LEDS - 1;
      default: return $urandom_range(0, NUM_LEDS - 1);
    endcase
  endfunction

  // Monitor: pop one expectation per presented pixel.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus.o_valid === 1'b1) begin
      if (bus.o_go === 1'b1) n_go_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pixel", {8'd0, bus.o_green_intensity, bus.o_red_intensity, bus.o_blue_intensity},
              {8'd0, e.pix});
        check("countdown", 32'(bus.countdown), e.cd);
        check("go", 32'(bus.o_go), 32'(e.go));
      end
    end
  end

  initial begin
    int idx;
    idx = 0;
    for (int r = 0; r < NR; r++)
      for (int p = 0; p < NP; p++)
        for (int k = 0; k < NR + 1 - r; k++) begin
          tab_row[idx] = r; tab_seg[idx] = p; tab_k[idx] = k;
          idx++;
        end

    rst_n = 1'b0;
    bus.enable = 1'b0; bus.led_valid = 1'b0; bus.led_number = '0; bus.ready_to_play = '0;
    bus.i_red_intensity = '0; bus.i_green_intensity = '0; bus.i_blue_intensity = '0;
    m_mode = M_IDLE; m_run = 0; m_en = 0; m_go = 0; m_pix = '0;
    step(); step();
    rst_n = 1'b1;

    // Full scan in IDLE, nobody ready: markers, apex, blinking bars.
    bus.enable = 1'b1; bus.led_valid = 1'b1;
    for (int i = 0; i < NUM_LEDS; i++) begin
      bus.led_number = 7'(i);
      step();
    end

    // Two players ready: full countdown to go, then a few cycles in DONE.
    bus.ready_to_play = 4'b0011;
    for (int i = 0; i < 34; i++) begin
      bus.led_number = 7'(pick_led());
      step();
    end

    // Disabled: registered pass-through of upstream pixels.
    bus.enable = 1'b0;
    bus.i_red_intensity = 8'hAA; bus.i_green_intensity = 8'h55; bus.i_blue_intensity = 8'h0F;
    step();
    for (int i = 0; i < 5; i++) begin
      bus.i_red_intensity   = 8'($urandom());
      bus.i_green_intensity = 8'($urandom());
      bus.i_blue_intensity  = 8'($urandom());
      bus.led_number        = 7'($urandom_range(0, 127));
      step();
    end

    // Enabled, out-of-range LED renders black.
    bus.enable = 1'b1; bus.ready_to_play = 4'b0000; bus.led_number = 7'd120;
    step(); step();

    // Abort at countdown 4 on the very edge a decrement is due.
    bus.ready_to_play = 4'b0011;
    for (int i = 0; i < 1 + 15; i++) begin
      bus.led_number = 7'(pick_led());
      step();
    end
    bus.ready_to_play = 4'b0001;
    bus.led_number = 7'd0;
    step(); step();

    // LED 9 blinks in IDLE, then steady green once its player is ready.
    bus.led_number = 7'd9;
    for (int i = 0; i < 12; i++) step();
    bus.ready_to_play = 4'b0011;
    for (int i = 0; i < 4; i++) step();

    // Randomised mixed traffic.
    for (int i = 0; i < 300; i++) begin
      bus.enable            = ($urandom_range(0, 15) != 0);
      bus.led_valid         = ($urandom_range(0, 9) != 0);
      bus.led_number        = 7'($urandom_range(0, 127));
      bus.i_red_intensity   = 8'($urandom());
      bus.i_green_intensity = 8'($urandom());
      bus.i_blue_intensity  = 8'($urandom());
      if ($urandom_range(0, 7) == 0) bus.ready_to_play = 4'($urandom());
      step();
    end

    // Reset pulse in the middle of a countdown.
    bus.enable = 1'b1; bus.led_valid = 1'b1; bus.ready_to_play = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      bus.led_number = 7'(pick_led());
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.led_number = 7'(pick_led());
      step();
    end

    // Drain and final bookkeeping.
    bus.led_valid = 1'b0;
    step(); step(); step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("go_pulses", 32'(n_go_seen), 32'(n_go_exp));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
